// File: rtl/gp_bus_sequencer_if.sv
// Command handshake and register-strobe bundle between a move issuer and gp_bus_sequencer.
// Active-low strobes follow the gp_register pin naming.
interface gp_bus_sequencer_if #(
  parameter int NREGS = 8,
  parameter int SELW  = 3
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [SELW-1:0]  cmd_src;
  logic             cmd_src_imm;
  logic [15:0]      cmd_imm;
  logic [SELW-1:0]  cmd_dst;
  logic [NREGS-1:0] reg_notOE;
  logic [NREGS-1:0] reg_notLoad;
  logic             imm_oe;
  logic [15:0]      imm_data;
  logic [15:0]      bus_in;
  logic [15:0]      rd_data;
  logic             done;
  logic             err;

  modport master (
    output cmd_valid, cmd_src, cmd_src_imm, cmd_imm, cmd_dst, bus_in,
    input  cmd_ready, reg_notOE, reg_notLoad, imm_oe, imm_data, rd_data, done, err
  );

  modport slave (
    input  cmd_valid, cmd_src, cmd_src_imm, cmd_imm, cmd_dst, bus_in,
    output cmd_ready, reg_notOE, reg_notLoad, imm_oe, imm_data, rd_data, done, err
  );
endinterface

// File: rtl/gp_bus_sequencer.sv
// Sequences one shared-bus move at a time: DRIVE (settle) -> LOAD (capture) -> RELEASE (turnaround).
// Every strobe is registered and derived from the next state, so it lines up with the state it belongs to.
module gp_bus_sequencer #(
  parameter int NREGS = 8,
  parameter int SELW  = 3
) (
  input  logic               clock,
  input  logic               reset,
  gp_bus_sequencer_if.slave  bus
);
  typedef enum logic [2:0] {IDLE, DRIVE, LOAD, RELEASE, ERR} state_t;

  typedef struct packed {
    logic [SELW-1:0] src;
    logic [SELW-1:0] dst;
    logic            src_imm;
  } cmd_t;

  state_t           state, state_nxt;
  cmd_t             cmd_q, cmd_nxt, cmd_in;
  logic             accept, bad;
  logic [NREGS-1:0] src_hot, dst_hot;
  logic [NREGS-1:0] notoe_nxt, notload_nxt, notoe_q, notload_q;
  logic             imm_oe_nxt, done_nxt, err_nxt;
  logic             imm_oe_q, done_q, err_q;
  logic [15:0]      imm_q, rd_q;

  assign bus.cmd_ready = (state == IDLE);
  assign accept        = bus.cmd_valid && (state == IDLE);
  assign cmd_in        = {bus.cmd_src, bus.cmd_dst, bus.cmd_src_imm};
  assign bad           = (int'(cmd_in.dst) >= NREGS) ||
                         (!cmd_in.src_imm && (int'(cmd_in.src) >= NREGS));

  always_comb begin
    state_nxt = state;
    cmd_nxt   = cmd_q;
    case (state)
      IDLE: if (accept) begin
        cmd_nxt   = cmd_in;
        state_nxt = bad ? ERR : DRIVE;
      end
      DRIVE:   state_nxt = LOAD;
      LOAD:    state_nxt = RELEASE;
      RELEASE: state_nxt = IDLE;
      ERR:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // One-hot selects for the command that will be in force next cycle
  for (genvar i = 0; i < NREGS; i++) begin : g_dec
    assign src_hot[i] = !cmd_nxt.src_imm && (int'(cmd_nxt.src) == i);
    assign dst_hot[i] = (int'(cmd_nxt.dst) == i);
  end

  always_comb begin
    notoe_nxt   = '1;
    notload_nxt = '1;
    imm_oe_nxt  = 1'b0;
    if (state_nxt == DRIVE || state_nxt == LOAD) begin
      notoe_nxt  = ~src_hot;
      imm_oe_nxt = cmd_nxt.src_imm;
    end
    if (state_nxt == LOAD) notload_nxt = ~dst_hot;
    done_nxt = (state_nxt == RELEASE);
    err_nxt  = (state_nxt == ERR);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      cmd_q     <= '0;
      notoe_q   <= '1;
      notload_q <= '1;
      imm_oe_q  <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      imm_q     <= '0;
      rd_q      <= '0;
    end else begin
      state     <= state_nxt;
      cmd_q     <= cmd_nxt;
      notoe_q   <= notoe_nxt;
      notload_q <= notload_nxt;
      imm_oe_q  <= imm_oe_nxt;
      done_q    <= done_nxt;
      err_q     <= err_nxt;
      if (accept && !bad && bus.cmd_src_imm) imm_q <= bus.cmd_imm;
      // Destination register captures on this same edge
      if (state == LOAD) rd_q <= bus.bus_in;
    end
  end

  assign bus.reg_notOE   = notoe_q;
  assign bus.reg_notLoad = notload_q;
  assign bus.imm_oe      = imm_oe_q;
  assign bus.imm_data    = imm_q;
  assign bus.rd_data     = rd_q;
  assign bus.done        = done_q;
  assign bus.err         = err_q;
endmodule

// File: tb/tb_gp_bus_sequencer.sv
// Bench for gp_bus_sequencer: emulated register file on a resolved bus, move-level model, per-cycle compare.
module tb_gp_bus_sequencer;
  localparam int NREGS = 8;
  localparam int SELW  = 3;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  gp_bus_sequencer_if #(.NREGS(NREGS), .SELW(SELW)) b();
  gp_bus_sequencer_if #(.NREGS(6), .SELW(SELW))     b6();

  gp_bus_sequencer #(.NREGS(NREGS), .SELW(SELW)) dut  (.clock(clock), .reset(reset), .bus(b));
  gp_bus_sequencer #(.NREGS(6), .SELW(SELW))     dut6 (.clock(clock), .reset(reset), .bus(b6));

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Register file and bus as the gp_register instances would present them
  logic [15:0] env_regs [NREGS];
  logic [15:0] bus_w;
  int drivers, loaders;

  always_comb begin
    bus_w   = '0;
    drivers = 0;
    loaders = 0;
    for (int i = 0; i < NREGS; i++) begin
      if (!b.reg_notOE[i]) begin bus_w |= env_regs[i]; drivers++; end
      if (!b.reg_notLoad[i]) loaders++;
    end
    if (b.imm_oe) begin bus_w |= b.imm_data; drivers++; end
  end
  assign b.bus_in  = bus_w;
  assign b6.bus_in = 16'h0;

  always @(posedge clock) begin
    cyc <= cyc + 1;
    for (int i = 0; i < NREGS; i++)
      if (!b.reg_notLoad[i]) env_regs[i] <= bus_w;
  end

  // Move-level model: a move occupies the 3 cycles after acceptance, an error the 1 after.
  int          age = 99;
  int          len = 4;
  logic        m_err = 1'b0, m_imm = 1'b0;
  logic [2:0]  m_src = '0, m_dst = '0;
  logic [15:0] m_word = '0, exp_rd = '0, exp_imm = '0;
  logic [15:0] mdl_regs [NREGS] = '{default: 16'h0};
  bit          armed = 1'b0;

  initial forever begin
    @(posedge clock);
    if (reset) begin
      age = 99; exp_rd = '0; exp_imm = '0; armed = 1'b1;
    end else if (age >= len) begin
      if (b.cmd_valid) begin
        m_src = b.cmd_src; m_dst = b.cmd_dst; m_imm = b.cmd_src_imm;
        m_err = (int'(m_dst) >= NREGS) || (!m_imm && int'(m_src) >= NREGS);
        len   = m_err ? 2 : 4;
        age   = 1;
        m_word = m_imm ? b.cmd_imm : mdl_regs[m_src];
        if (m_imm && !m_err) exp_imm = b.cmd_imm;
      end
    end else begin
      age++;
      if (age == 3 && !m_err) begin
        mdl_regs[m_dst] = m_word;
        exp_rd = m_word;
      end
    end
  end

  int imm_cycles = 0;
  int done_q [$];

  initial forever begin
    logic busy, drv;
    logic [NREGS-1:0] e_oe, e_ld;
    @(negedge clock);
    if (armed) begin
      busy = (age < len);
      drv  = busy && !m_err && (age == 1 || age == 2);
      e_oe = '1;
      if (drv && !m_imm) e_oe[m_src] = 1'b0;
      e_ld = '1;
      if (busy && !m_err && age == 2) e_ld[m_dst] = 1'b0;
      chk("cmd_ready", b.cmd_ready, !busy);
      chk("reg_notOE", b.reg_notOE, e_oe);
      chk("reg_notLoad", b.reg_notLoad, e_ld);
      chk("imm_oe", b.imm_oe, drv && m_imm);
      chk("done", b.done, busy && !m_err && age == 3);
      chk("err", b.err, busy && m_err && age == 1);
      chk("rd_data", b.rd_data, exp_rd);
      if (b.imm_oe) chk("imm_data", b.imm_data, exp_imm);
      chk("single_driver", drivers <= 1, 1'b1);
      chk("single_loader", loaders <= 1, 1'b1);
      if (b.imm_oe) imm_cycles++;
      if (b.done) done_q.push_back(cyc);
    end
  end

  task automatic issue(input logic [2:0] src, input logic imm_f, input logic [15:0] imm,
                       input logic [2:0] dst);
    @(negedge clock);
    b.cmd_src = src; b.cmd_src_imm = imm_f; b.cmd_imm = imm; b.cmd_dst = dst;
    b.cmd_valid = 1'b1;
    for (int k = 0; k < 16; k++) begin
      if (b.cmd_ready) begin @(posedge clock); return; end
      @(negedge clock);
    end
    chk("accept_timeout", 1'b0, 1'b1);
  endtask

  task automatic drop();
    @(negedge clock);
    b.cmd_valid = 1'b0;
  endtask

  task automatic settle(input int n);
    repeat (n) @(negedge clock);
    #1;
  endtask

  task automatic b6_cmd(input logic [2:0] src, input logic imm_f, input logic [2:0] dst);
    @(negedge clock);
    b6.cmd_src = src; b6.cmd_src_imm = imm_f; b6.cmd_imm = 16'h5555; b6.cmd_dst = dst;
    b6.cmd_valid = 1'b1;
    @(negedge clock);
    b6.cmd_valid = 1'b0;
  endtask

  initial begin
    b.cmd_valid = 1'b0; b.cmd_src = '0; b.cmd_src_imm = 1'b0; b.cmd_imm = '0; b.cmd_dst = '0;
    b6.cmd_valid = 1'b0; b6.cmd_src = '0; b6.cmd_src_imm = 1'b0; b6.cmd_imm = '0; b6.cmd_dst = '0;
    reset = 1'b1;
    repeat (2) @(negedge clock);
    chk("rst_ready", b.cmd_ready, 1'b1);
    chk("rst_notOE", b.reg_notOE, 8'hFF);
    chk("rst_notLoad", b.reg_notLoad, 8'hFF);
    chk("rst_no_driver", drivers, 0);
    chk("rst_imm_data", b.imm_data, 16'h0);
    reset = 1'b0;

    // Immediate into reg0
    imm_cycles = 0;
    issue(3'd0, 1'b1, 16'hBEEF, 3'd0); drop(); settle(4);
    chk("t2_rd", b.rd_data, 16'hBEEF);
    chk("t2_reg0", env_regs[0], 16'hBEEF);
    chk("t2_imm_cycles", imm_cycles, 2);

    // Register chain reg0 -> reg5 -> reg6
    issue(3'd0, 1'b0, 16'h0, 3'd5); drop(); settle(4);
    chk("t3_reg5", env_regs[5], 16'hBEEF);
    issue(3'd5, 1'b0, 16'h0, 3'd6); drop(); settle(4);
    chk("t3_rd", b.rd_data, 16'hBEEF);
    chk("t3_reg6", env_regs[6], 16'hBEEF);

    // Back-to-back with valid held high
    done_q.delete();
    issue(3'd0, 1'b1, 16'h1234, 3'd1);
    issue(3'd1, 1'b0, 16'h0, 3'd2);
    issue(3'd0, 1'b1, 16'hA5A5, 3'd3);
    drop(); settle(5);
    chk("t4_done_count", done_q.size(), 3);
    if (done_q.size() == 3) begin
      chk("t4_gap0", done_q[1] - done_q[0], 4);
      chk("t4_gap1", done_q[2] - done_q[1], 4);
    end
    chk("t4_reg2", env_regs[2], 16'h1234);
    chk("t4_rd", b.rd_data, 16'hA5A5);

    // Self move
    issue(3'd2, 1'b0, 16'h0, 3'd2); drop(); settle(4);
    chk("self_rd", b.rd_data, 16'h1234);
    chk("self_reg2", env_regs[2], 16'h1234);

    // Out-of-range indices on the 6-register instance
    b6_cmd(3'd0, 1'b0, 3'd7);
    chk("t5_err", b6.err, 1'b1);
    chk("t5_busy", b6.cmd_ready, 1'b0);
    chk("t5_notOE", b6.reg_notOE, 6'h3F);
    chk("t5_notLoad", b6.reg_notLoad, 6'h3F);
    chk("t5_imm_oe", b6.imm_oe, 1'b0);
    chk("t5_done", b6.done, 1'b0);
    @(negedge clock);
    chk("t5_err_clr", b6.err, 1'b0);
    chk("t5_ready", b6.cmd_ready, 1'b1);
    chk("t5_no_done", b6.done, 1'b0);
    b6_cmd(3'd6, 1'b0, 3'd1);
    chk("t5_src_err", b6.err, 1'b1);
    chk("t5_src_notOE", b6.reg_notOE, 6'h3F);
    @(negedge clock);
    b6_cmd(3'd0, 1'b1, 3'd5);
    chk("t5_ok_err", b6.err, 1'b0);
    chk("t5_ok_imm_oe", b6.imm_oe, 1'b1);
    @(negedge clock);
    chk("t5_ok_load", b6.reg_notLoad, 6'h1F);
    @(negedge clock);
    chk("t5_ok_done", b6.done, 1'b1);

    // Reset in the middle of LOAD
    issue(3'd0, 1'b1, 16'h0F0F, 3'd7);
    drop();
    @(negedge clock);
    chk("t6_in_load", b.reg_notLoad, 8'h7F);
    reset = 1'b1;
    @(negedge clock);
    chk("t6_notLoad", b.reg_notLoad, 8'hFF);
    chk("t6_notOE", b.reg_notOE, 8'hFF);
    chk("t6_imm_oe", b.imm_oe, 1'b0);
    chk("t6_done", b.done, 1'b0);
    chk("t6_ready", b.cmd_ready, 1'b1);
    reset = 1'b0;
    settle(3);
    issue(3'd6, 1'b0, 16'h0, 3'd4); drop(); settle(4);
    chk("t6_after_rd", b.rd_data, 16'hBEEF);
    chk("t6_after_reg4", env_regs[4], 16'hBEEF);

    settle(2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, %0d vectors applied", n_vec);
    $fatal(1, "timeout");
  end
endmodule
